// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner.
//   key_state_e : per-channel debounce state
//   DEFAULT_*   : default timing constants (in clk cycles)
package key_pkg;

    typedef enum logic [1:0] {
        KEY_RELEASED,
        KEY_PRESS_PEND,
        KEY_PRESSED,
        KEY_RELEASE_PEND
    } key_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEFAULT_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned DEFAULT_REPEAT_RATE     = 5_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM/counter, press/release pulses.
// Optional auto-repeat when KEY_AUTOREPEAT_EN is defined.
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   key_sw      raw key pin, active-low, asynchronous
//   key_level   debounced level, active-high
//   key_press   1-cycle pulse on accepted press (and on auto-repeat)
//   key_release 1-cycle pulse on accepted release
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEFAULT_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_sw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    // Synchronizer holds the raw (active-low) pin; inversion happens after flop 2.
    logic sync_q1, sync_q2;
    logic pressed_s;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_sw;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed_s = ~sync_q2;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    // Set until the first repeat fires; selects DELAY vs RATE as the period.
    logic             rpt_first_q, rpt_first_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        unique case (state_q)
            KEY_RELEASED: begin
                if (pressed_s) begin
                    state_d = KEY_PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            KEY_PRESS_PEND: begin
                if (!pressed_s) begin
                    state_d = KEY_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = KEY_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            KEY_PRESSED: begin
                if (!pressed_s) begin
                    state_d = KEY_RELEASE_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            KEY_RELEASE_PEND: begin
                if (pressed_s) begin
                    state_d = KEY_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = KEY_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = KEY_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

`ifdef KEY_AUTOREPEAT_EN
        // Repeat timer only runs while stably held; any other state clears it.
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        if ((state_q == KEY_PRESSED) && pressed_s) begin
            rpt_first_d = rpt_first_q;
            if (rpt_first_q && (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1))) begin
                press_d     = 1'b1;
                rpt_first_d = 1'b0;
            end else if (!rpt_first_q && (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1))) begin
                press_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= KEY_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button input conditioner: N_KEYS independent debounce channels.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat key_press while held).
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   key_sw      raw key pins, active-low, asynchronous
//   key_level   debounced levels, active-high
//   key_press   1-cycle pulses on accepted press
//   key_release 1-cycle pulses on accepted release
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_sw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    // Elaboration-time guard against timing values the channel cannot honour.
    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_param_check
        $error("key_debounce: invalid timing parameters");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
`endif
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_sw     (key_sw[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RR = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] key_sw;
    logic [N-1:0] key_level, key_press, key_release;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS         (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_sw     (key_sw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Is a repeat pulse due after h stable held cycles since acceptance?
    function automatic bit rep_due(input int h);
`ifdef KEY_AUTOREPEAT_EN
        return (h == RD) || ((h > RD) && (((h - RD) % RR) == 0));
`else
        return (h < 0);
`endif
    endfunction

    // Reference model: a change of the synchronized value is accepted once it has
    // persisted for D+1 consecutive samples; hold counts samples since acceptance.
    bit           m_s1[N], m_s2[N], m_lvl[N];
    int           m_run[N], m_hold[N];
    logic [N-1:0] exp_level, exp_press, exp_release;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < N; ch++) begin
                m_s1[ch]   <= 1'b0;
                m_s2[ch]   <= 1'b0;
                m_lvl[ch]  <= 1'b0;
                m_run[ch]  <= 0;
                m_hold[ch] <= 0;
            end
            exp_level   <= '0;
            exp_press   <= '0;
            exp_release <= '0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                bit ps, lvl, pr, rl;
                int run, hold;
                ps   = m_s2[ch];
                lvl  = m_lvl[ch];
                run  = m_run[ch];
                hold = m_hold[ch];
                pr   = 1'b0;
                rl   = 1'b0;
                if (ps != lvl) begin
                    run++;
                    if (run == D + 1) begin
                        lvl  = ps;
                        run  = 0;
                        hold = 0;
                        if (ps) pr = 1'b1;
                        else rl = 1'b1;
                    end
                end else begin
                    if (lvl) begin
                        if (run > 0) hold = 0;
                        else begin
                            hold++;
                            pr = rep_due(hold);
                        end
                    end
                    run = 0;
                end
                m_s1[ch]        <= ~key_sw[ch];
                m_s2[ch]        <= m_s1[ch];
                m_lvl[ch]       <= lvl;
                m_run[ch]       <= run;
                m_hold[ch]      <= hold;
                exp_level[ch]   <= lvl;
                exp_press[ch]   <= pr;
                exp_release[ch] <= rl;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("level", 32'(key_level), 32'(exp_level));
            check("press", 32'(key_press), 32'(exp_press));
            check("release", 32'(key_release), 32'(exp_release));
            check("press_and_release", 32'(key_press & key_release), 32'd0);
        end
    end

    // Returns edge index (0 = first edge after the stimulus change) of the pulse.
    task automatic wait_pulse(input int ch, input bit is_press, output int edge_n);
        edge_n = -1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (is_press ? key_press[ch] : key_release[ch]) begin
                edge_n = n;
                return;
            end
        end
    endtask

    initial begin
        int e;
        logic [3:0] exp_rep;
        key_sw = 4'hF;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Test 1: quiet after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({key_level, key_press, key_release}), 32'd0);
        end

        // Test 2: press key 0, plus repeat behaviour while held
        key_sw[0] = 1'b0;
        wait_pulse(0, 1'b1, e);
        check("press0_edge", 32'(e), 32'd10);
        check("press0_level", 32'(key_level), 32'b0001);
        for (int n = 11; n <= 45; n++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef KEY_AUTOREPEAT_EN
            exp_rep = (n == 30 || n == 36 || n == 42) ? 4'd1 : 4'd0;
`else
            exp_rep = 4'd0;
`endif
            check("repeat0", 32'(key_press[0]), 32'(exp_rep));
        end

        // Test 3: short glitch on key 1 ignored
        key_sw[1] = 1'b0;
        repeat (5) @(negedge clk);
        key_sw[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("glitch1_press", 32'(key_press[1]), 32'd0);
        end
        check("glitch1_level", 32'(key_level), 32'b0001);

        // Test 4: release key 0
        key_sw[0] = 1'b1;
        wait_pulse(0, 1'b0, e);
        check("release0_edge", 32'(e), 32'd10);
        check("release0_level", 32'(key_level), 32'b0000);

        // Test 5: simultaneous press on keys 1 and 3
        repeat (2) @(negedge clk);
        key_sw = 4'b0101;
        wait_pulse(1, 1'b1, e);
        check("simul_edge", 32'(e), 32'd10);
        check("simul_press", 32'(key_press), 32'b1010);
        key_sw = 4'hF;
        repeat (20) @(negedge clk);
        check("simul_released", 32'(key_level), 32'b0000);

        // Test 6: reset mid-pending discards count
        key_sw[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("pend2_no_press", 32'(key_press[2]), 32'd0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({key_level, key_press, key_release}), 32'd0);
        rst = 1'b0;
        wait_pulse(2, 1'b1, e);
        check("press2_after_rst_edge", 32'(e), 32'd10);
        key_sw = 4'hF;
        repeat (20) @(negedge clk);

        // Randomized bouncing with occasional resets, checked by the model
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 1499) == 0) rst = 1'b1;
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 15) == 0) key_sw[ch] = ~key_sw[ch];
            end
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
